// File: rtl/life_pkg.sv
// Shared constants, rule presets and width helpers
// for the life-like cellular automaton cells.
package life_pkg;

  localparam int STATE_DEAD    = 0;
  localparam int STATE_ALIVE   = 1;
  localparam int MAX_NEIGHBORS = 24;

  typedef struct packed {
    logic [8:0] birth;
    logic [8:0] survive;
  } rule_t;

  localparam rule_t RULE_B3_S23 = '{
    birth:   9'b000001000,
    survive: 9'b000001100
  };

  localparam rule_t RULE_B36_S23 = '{
    birth:   9'b001001000,
    survive: 9'b000001100
  };

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int state_width(input int s);
    return (s <= 2) ? 1 : $clog2(s);
  endfunction

endpackage

// File: rtl/life_neighbor_count.sv
// Parametrised popcount built as a recursive
// binary adder tree over the neighbour bits.
module life_neighbor_count
  import life_pkg::*;
#(
  parameter  int N_NEIGHBORS = 8,
  localparam int CNT_W = cnt_width(N_NEIGHBORS)
) (
  input  logic [N_NEIGHBORS-1:0] neighbors,
  output logic [CNT_W-1:0]       count
);

  generate
    if (N_NEIGHBORS == 1) begin : g_leaf
      assign count = neighbors;
    end else begin : g_split
      localparam int NL = N_NEIGHBORS / 2;
      localparam int NH = N_NEIGHBORS - NL;
      localparam int WL = cnt_width(NL);
      localparam int WH = cnt_width(NH);

      logic [WL-1:0] cnt_lo;
      logic [WH-1:0] cnt_hi;

      life_neighbor_count #(
        .N_NEIGHBORS(NL)
      ) u_lo (
        .neighbors(neighbors[NL-1:0]),
        .count    (cnt_lo)
      );

      life_neighbor_count #(
        .N_NEIGHBORS(NH)
      ) u_hi (
        .neighbors(neighbors[N_NEIGHBORS-1:NL]),
        .count    (cnt_hi)
      );

      assign count = CNT_W'(cnt_lo)
                   + CNT_W'(cnt_hi);
    end
  endgenerate

endmodule

// File: rtl/life_cell_gen.sv
// One life-like cell with runtime rules, decay states
// and age; LIFE_CELL_CHANGE_DETECT_EN adds changed flag.
module life_cell_gen
  import life_pkg::*;
#(
  parameter  int N_NEIGHBORS = 8,
  parameter  int STATES      = 2,
  parameter  int AGE_W       = 4,
  localparam int STATE_W = state_width(STATES),
  localparam int CNT_W   = cnt_width(N_NEIGHBORS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   load,
  input  logic                   state_0,
  input  logic [N_NEIGHBORS:0]   birth_mask,
  input  logic [N_NEIGHBORS:0]   survive_mask,
  input  logic [N_NEIGHBORS-1:0] neighbors,
  output logic                   alive,
  output logic [STATE_W-1:0]     state_q,
  output logic [AGE_W-1:0]       age,
  output logic [CNT_W-1:0]       live_count,
  output logic                   changed
);

  localparam logic [STATE_W-1:0] ST_DEAD =
    STATE_W'(STATE_DEAD);
  localparam logic [STATE_W-1:0] ST_ALIVE =
    STATE_W'(STATE_ALIVE);
  localparam logic [STATE_W-1:0] ST_DECAY =
    (STATES == 2) ? ST_DEAD : STATE_W'(2);
  localparam logic [STATE_W-1:0] ST_LAST =
    STATE_W'(STATES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [CNT_W-1:0]   n;
  logic [STATE_W-1:0] state_d;
  logic [AGE_W-1:0]   age_q;
  logic [AGE_W-1:0]   age_d;
  logic               alive_q;

  life_neighbor_count #(
    .N_NEIGHBORS(N_NEIGHBORS)
  ) u_cnt (
    .neighbors(neighbors),
    .count    (n)
  );

  assign live_count = n;
  assign age        = age_q;
  assign alive      = alive_q;

  // Next generation: load wins, then ena, else hold
  always_comb begin
    state_d = state_q;
    age_d   = age_q;
    unique case (1'b1)
      load: begin
        state_d = STATE_W'(state_0);
        age_d   = '0;
      end
      (ena && !load): begin
        age_d = '0;
        if (state_q == ST_DEAD) begin
          state_d = birth_mask[n] ? ST_ALIVE
                                  : ST_DEAD;
        end else if (state_q == ST_ALIVE) begin
          if (survive_mask[n]) begin
            state_d = ST_ALIVE;
            age_d   = (age_q == AGE_MAX) ? age_q
                    : age_q + AGE_W'(1);
          end else begin
            state_d = ST_DECAY;
          end
        end else if (state_q < ST_LAST) begin
          state_d = state_q + STATE_W'(1);
        end else begin
          state_d = ST_DEAD;
        end
      end
      default: ;
    endcase
  end

  // State, age and alive registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_DEAD;
      age_q   <= '0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
      alive_q <= (state_d == ST_ALIVE);
    end
  end

`ifdef LIFE_CELL_CHANGE_DETECT_EN
  logic changed_q;

  // Flag a state change caused by a load/ena step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= (load || ena)
                && (state_d != state_q);
    end
  end

  assign changed = changed_q;
`else
  assign changed = 1'b0;
`endif

endmodule

// File: doc/life_cell_gen.md
Name: life_cell_gen

Overview:
- Parametrised next-generation Game-of-Life cell for the lab grid.
- Supports a configurable neighbourhood size and runtime birth/survive rule masks, so one cell covers any life-like rule (B3/S23, HighLife, ...).
- Supports multi-state "Generations" decay, a saturating age counter and an optional change-detect flag.
- One instance per grid site, tiled by the board-level array; neighbours come from adjacent cells' alive outputs.

Parameters:
- N_NEIGHBORS, 8, number of neighbour inputs; legal range 1..24 (8 = Moore r1, 4 = von Neumann, 24 = Moore r2).
- STATES, 2, total cell states; 2 = classic life, >2 enables decay states 2..STATES-1; legal range 2..16.
- AGE_W, 4, width of the saturating age counter; legal range 1..16.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-low reset.
- ena  input  1  advance one generation this cycle.
- load  input  1  synchronous load of state_0; has priority over ena.
- state_0  input  1  value to load: 1 = alive, 0 = dead.
- birth_mask  input  N_NEIGHBORS+1  bit k set: a dead cell with k live neighbours is born.
- survive_mask  input  N_NEIGHBORS+1  bit k set: an alive cell with k live neighbours survives.
- neighbors  input  N_NEIGHBORS  alive bits of the neighbouring cells.
- alive  output  1  high iff state_q == 1; registered.
- state_q  output  STATE_W  current state index; STATE_W = max(1, $clog2(STATES)).
- age  output  AGE_W  enabled generations survived since birth/load.
- live_count  output  CNT_W  combinational popcount of neighbors; CNT_W = $clog2(N_NEIGHBORS+1); debug.
- changed  output  1  see Optional Feature.

Behaviour:
- Reset (rst low, asynchronous): state_q = 0, age = 0, changed = 0. Takes effect mid-generation regardless of ena/load.
- Priority each posedge with rst high: load > ena > hold.
- load = 1:
  - state_q <= state_0 (0 or 1); age <= 0.
  - ena is ignored that cycle.
- ena = 1, load = 0: n = live_count, then by current state:
  - state 0: birth_mask[n] ? 1 : 0. age <= 0.
  - state 1, survive_mask[n] = 1: stays 1; age <= age + 1, saturating at 2^AGE_W - 1.
  - state 1, survive_mask[n] = 0: goes to 0 if STATES == 2, else to 2. age <= 0.
  - state k >= 2: k+1 if k < STATES-1, else 0. Neighbours are ignored; the cell is refractory and cannot be born. age stays 0.
- Neither load nor ena: all registers hold.
- Latency: one cycle from ena/load to the updated state_q/alive/age.
- Only alive (state 1) counts as a live neighbour; decay states read as 0 on alive.
- Illegal state_q values (>= STATES, reachable only via SEU) go to 0 on the next ena.
- n is always <= N_NEIGHBORS, so mask indexing never runs out of range.
- Age saturates and does not wrap: at 2^AGE_W - 1 it holds while the cell keeps surviving.
- Mask changes take effect on the next ena; there is no internal mask register.

Optional Feature:
- Macro: LIFE_CELL_CHANGE_DETECT_EN.
- Defined: changed is a registered flag, set for exactly the cycle after any ena/load step in which state_q's new value differs from its old value. Cleared otherwise and on reset. The board uses it for an "all stable" AND-reduction.
- Undefined: changed is tied to 0 and no extra flop is generated.

Decomposition:
- Package life_pkg:
  - STATE_DEAD = 0, STATE_ALIVE = 1, MAX_NEIGHBORS = 24.
  - Rule constants RULE_B3_S23 (birth = 9'b000001000, survive = 9'b000001100) and RULE_B36_S23 (HighLife).
  - Width helper functions for CNT_W and STATE_W.
- Sub-module life_neighbor_count: parametrised combinational popcount adder tree, N_NEIGHBORS in, CNT_W out. Replaces the fixed 8-input adder chain; reusable by the board's population counter.

Test Plan:
- Classic rule: STATES=2, RULE_B3_S23. Load dead, neighbors=8'b00000111, ena -> alive=1 next cycle, age=0. Next ena with 2 neighbours -> alive=1, age=1. Next ena with 4 neighbours -> alive=0, age=0.
- Generations decay: STATES=4, alive cell, 0 neighbours, ena x4 -> state_q 2, 3, 0, 0. With 3 neighbours held during states 2 and 3, no birth occurs.
- Age saturation: AGE_W=2, alive, 2 neighbours, ena x5 -> age 1, 2, 3, 3, 3.
- Priority and async reset: load=1, state_0=1, ena=1, 0 neighbours -> state_q=1, age=0. Pulse rst low mid-cycle between clock edges -> state_q=0 immediately, before the next edge.
- Parametric: N_NEIGHBORS=24, all 24 neighbours high, birth_mask bit 24 set -> live_count=24, birth occurs. With bit 24 clear -> stays dead.
- LIFE_CELL_CHANGE_DETECT_EN defined: a birth step gives changed=1 for one cycle; a survive step gives changed=0. With the macro undefined, changed stays 0 throughout.
